// File: rtl/ddr3_wr_pkg.sv
// Shared constants for the DDR3 write-path tristate generator.
// Slot counts and mask sizing used by the top and the slot masks.
package ddr3_wr_pkg;

  localparam int BL_SLOTS   = 4;
  localparam int PRE_SLOTS  = 1;
  localparam int POST_SLOTS = 1;

  localparam int DQS_LEN = PRE_SLOTS + BL_SLOTS + POST_SLOTS;
  localparam int DQ_LEN  = PRE_SLOTS + BL_SLOTS;

  localparam logic [DQS_LEN-1:0] DQS_PAT = '1;
  // DQ shares the DQS insert offset, so its pattern skips the preamble slot
  localparam logic [DQ_LEN-1:0]  DQ_PAT  =
    DQ_LEN'(((1 << BL_SLOTS) - 1) << PRE_SLOTS);

  function automatic int mask_w(input int wl);
    return 2 * wl + 8;
  endfunction

endpackage

// File: rtl/ddr3_wr_oe_gen_mask.sv
// Future-slot enable mask: shifts two slots per SCLK, ORs a burst
// pattern in at a slot offset, and registers the active-low T pair.
module ddr3_slot_mask #(
  parameter int              W    = 16,
  parameter int              PLEN = 6,
  parameter logic [PLEN-1:0] PAT  = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ins_i,
  input  logic [$clog2(W)-1:0] ofs_i,
  output logic [1:0]           t_o,
  output logic                 any_o
);

  logic [W-1:0] m_q;
  logic [W-1:0] m_d;
  logic [W-1:0] pat_w;
  logic [1:0]   t_q;

  // m_q bit 0 is the T0 slot of the cycle following the last edge
  always_comb begin
    pat_w = W'(PAT) << ofs_i;
    m_d   = (m_q | (ins_i ? pat_w : '0)) >> 2;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q <= '0;
      t_q <= 2'b11;
    end else begin
      m_q <= m_d;
      t_q <= ~m_q[1:0];
    end
  end

  assign t_o   = t_q;
  assign any_o = |m_q;

endmodule

// File: rtl/ddr3_wr_oe_gen.sv
// DDR3 write-path DQS/DQ output-enable generator with write latency,
// preamble/postamble, data-fetch strobe and request spacing check.
module ddr3_wr_oe_gen
  import ddr3_wr_pkg::*;
#(
  parameter int WL      = 4,
  parameter int RD_LEAD = 1
) (
  input  logic sclk_i,
  input  logic rst_i,
  input  logic wr_req_i,
  input  logic wr_odd_i,
  output logic dqs_t0_o,
  output logic dqs_t1_o,
  output logic dq_t0_o,
  output logic dq_t1_o,
  output logic data_rd_o,
  output logic data_odd_o,
  output logic busy_o,
  output logic err_o
);

  localparam int W  = mask_w(WL);
  localparam int OW = $clog2(W);
  localparam int N  = WL - RD_LEAD;

  logic          acc_q;
  logic          acc_d;
  logic          drop_q;
  logic          err_q;
  logic          busy_q;
  logic [N:0]    rd_q;
  logic [N:0]    odd_q;
  logic [OW-1:0] ofs;
  logic [1:0]    dqs_t;
  logic [1:0]    dq_t;
  logic          dqs_any;
  logic          dq_any;

  assign acc_d = wr_req_i & ~acc_q;
  assign ofs   = OW'(2 * WL - 1) + OW'(wr_odd_i);

  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      acc_q  <= 1'b0;
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      rd_q   <= '0;
      odd_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= wr_req_i & acc_q;
      err_q  <= drop_q;
      busy_q <= dqs_any | dq_any;
      rd_q   <= {rd_q[N-1:0], acc_d};
      odd_q  <= {odd_q[N-1:0], acc_d & wr_odd_i};
    end
  end

  ddr3_slot_mask #(
    .W    (W),
    .PLEN (DQS_LEN),
    .PAT  (DQS_PAT)
  ) u_dqs (
    .clk_i (sclk_i),
    .rst_i (rst_i),
    .ins_i (acc_d),
    .ofs_i (ofs),
    .t_o   (dqs_t),
    .any_o (dqs_any)
  );

  ddr3_slot_mask #(
    .W    (W),
    .PLEN (DQ_LEN),
    .PAT  (DQ_PAT)
  ) u_dq (
    .clk_i (sclk_i),
    .rst_i (rst_i),
    .ins_i (acc_d),
    .ofs_i (ofs),
    .t_o   (dq_t),
    .any_o (dq_any)
  );

  assign dqs_t0_o   = dqs_t[0];
  assign dqs_t1_o   = dqs_t[1];
  assign dq_t0_o    = dq_t[0];
  assign dq_t1_o    = dq_t[1];
  assign data_rd_o  = rd_q[N];
  assign data_odd_o = odd_q[N];
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule
